// File: rtl/beat_engine_pkg.sv
// Shared encodings and default tempo constants for the beat engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package beat_engine_pkg;

    // Level select codes carried on the mode input
    typedef enum logic [1:0] {
        MODE_ENDLESS = 2'd0,
        MODE_LEVEL_1 = 2'd1,
        MODE_LEVEL_2 = 2'd2,
        MODE_LEVEL_3 = 2'd3
    } mode_t;

    // Engine control states
    typedef enum logic [1:0] {
        BE_IDLE   = 2'd0,
        BE_RUN    = 2'd1,
        BE_PAUSED = 2'd2
    } be_state_t;

    // Default tempo constants
    localparam int DEF_TICK_HZ       = 10000;
    localparam int DEF_SUBDIV        = 10;
    localparam int DEF_BEATS_PER_BAR = 4;
    localparam int DEF_BPM_W         = 9;
    localparam int DEF_BPM_L1        = 60;
    localparam int DEF_BPM_L2        = 90;
    localparam int DEF_BPM_L3        = 120;
    localparam int DEF_BPM_START     = 60;
    localparam int DEF_BPM_MAX       = 240;
    localparam int DEF_RAMP_NUM      = 15;
    localparam int DEF_RAMP_DEN      = 14;

endpackage

// File: rtl/beat_engine_tempo_ramp.sv
// Endless-mode tempo register: multiplies by RAMP_NUM/RAMP_DEN per step, saturating.
// Latency: new tempo visible one clk after the step cycle.
// Backpressure: none; step is a qualified one-cycle pulse, clr wins over step.
module tempo_ramp #(
    parameter int BPM_W     = 9,
    parameter int BPM_START = 60,
    parameter int BPM_MAX   = 240,
    parameter int RAMP_NUM  = 15,
    parameter int RAMP_DEN  = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             step,
    output logic [BPM_W-1:0] bpm
);

    // One extra bit beyond the product width keeps bpm*RAMP_NUM from wrapping
    localparam int MUL_W = BPM_W + $clog2(RAMP_NUM) + 1;

    logic [MUL_W-1:0] prod;
    logic [MUL_W-1:0] quo;
    logic [MUL_W-1:0] nxt;

    // Next tempo: scaled value, forced to advance by at least 1, clipped at the ceiling
    always_comb begin
        prod = MUL_W'(bpm) * MUL_W'(RAMP_NUM);
        quo  = prod / MUL_W'(RAMP_DEN);
        nxt  = quo;
        if (quo == MUL_W'(bpm)) begin
            nxt = quo + MUL_W'(1);
        end
        if (nxt > MUL_W'(BPM_MAX)) begin
            nxt = MUL_W'(BPM_MAX);
        end
    end

    // Tempo register: back to the start tempo on reset or restart
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            bpm <= BPM_W'(BPM_START);
        end else if (step) begin
            bpm <= BPM_W'(nxt);
        end
    end

endmodule

// File: rtl/beat_engine.sv
// Tempo engine: phase-accumulator sub-beat/beat/bar pulse generator with run/pause control.
// Latency: sub/beat/bar pulses one clk after the qualifying tick_en, coincident, one cycle wide.
// Backpressure: none; tick_en/sec_en arriving in a pause or restart cycle are dropped.
module beat_engine
    import beat_engine_pkg::*;
#(
    parameter int TICK_HZ       = DEF_TICK_HZ,
    parameter int SUBDIV        = DEF_SUBDIV,
    parameter int BEATS_PER_BAR = DEF_BEATS_PER_BAR,
    parameter int BPM_W         = DEF_BPM_W,
    parameter int BPM_L1        = DEF_BPM_L1,
    parameter int BPM_L2        = DEF_BPM_L2,
    parameter int BPM_L3        = DEF_BPM_L3,
    parameter int BPM_START     = DEF_BPM_START,
    parameter int BPM_MAX       = DEF_BPM_MAX,
    parameter int RAMP_NUM      = DEF_RAMP_NUM,
    parameter int RAMP_DEN      = DEF_RAMP_DEN
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             tick_en,
    input  logic                             sec_en,
    input  logic [1:0]                       mode,
    input  logic                             start,
    input  logic                             pause,
    input  logic                             restart,
    output logic                             sub_pulse,
    output logic                             beat_pulse,
    output logic                             bar_pulse,
    output logic                             beat_level,
    output logic [$clog2(SUBDIV)-1:0]        sub_idx,
    output logic [$clog2(BEATS_PER_BAR)-1:0] beat_idx,
    output logic [BPM_W-1:0]                 bpm_cur,
    output logic                             running
);

    localparam int LIMIT  = TICK_HZ * 60;
    localparam int ACC_W  = $clog2(LIMIT + BPM_MAX * SUBDIV + 1);
    localparam int SUB_W  = $clog2(SUBDIV);
    localparam int BEAT_W = $clog2(BEATS_PER_BAR);

    localparam logic [ACC_W-1:0]  LIMIT_V   = ACC_W'(LIMIT);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SUBDIV - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS_PER_BAR - 1);

    // At most one sub-beat may fall due per tick, otherwise pulses would be lost
    if (BPM_MAX * SUBDIV >= LIMIT) begin : g_cfg_check
        $error("beat_engine: BPM_MAX*SUBDIV must be below TICK_HZ*60");
    end

    be_state_t        state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] sum;
    logic [BPM_W-1:0] bpm_ramp;
    logic             run_ok;
    logic             ramp_step;

    // Ticks and seconds only count in a clean RUN cycle (no pause, no restart)
    assign run_ok    = (state == BE_RUN) && !restart && !pause;
    assign ramp_step = run_ok && sec_en && (mode_t'(mode) == MODE_ENDLESS);

    tempo_ramp #(
        .BPM_W     (BPM_W),
        .BPM_START (BPM_START),
        .BPM_MAX   (BPM_MAX),
        .RAMP_NUM  (RAMP_NUM),
        .RAMP_DEN  (RAMP_DEN)
    ) u_tempo_ramp (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (restart),
        .step  (ramp_step),
        .bpm   (bpm_ramp)
    );

    // Active tempo follows mode directly; the accumulator sees it on the next tick
    always_comb begin
        bpm_cur = BPM_W'(BPM_L1);
        case (mode_t'(mode))
            MODE_ENDLESS: bpm_cur = bpm_ramp;
            MODE_LEVEL_1: bpm_cur = BPM_W'(BPM_L1);
            MODE_LEVEL_2: bpm_cur = BPM_W'(BPM_L2);
            MODE_LEVEL_3: bpm_cur = BPM_W'(BPM_L3);
            default:      bpm_cur = BPM_W'(BPM_L1);
        endcase
        inc = ACC_W'(bpm_cur) * ACC_W'(SUBDIV);
        sum = acc + inc;
    end

    // Control FSM, phase accumulator and position counters with registered pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= BE_IDLE;
            running    <= 1'b0;
            acc        <= '0;
            sub_idx    <= '0;
            beat_idx   <= '0;
            sub_pulse  <= 1'b0;
            beat_pulse <= 1'b0;
            bar_pulse  <= 1'b0;
            beat_level <= 1'b1;
        end else begin
            sub_pulse  <= 1'b0;
            beat_pulse <= 1'b0;
            bar_pulse  <= 1'b0;
            if (restart) begin
                state      <= BE_RUN;
                running    <= 1'b1;
                acc        <= '0;
                sub_idx    <= '0;
                beat_idx   <= '0;
                beat_level <= 1'b1;
            end else begin
                case (state)
                    BE_IDLE: begin
                        if (start) begin
                            state   <= BE_RUN;
                            running <= 1'b1;
                        end
                    end
                    BE_RUN: begin
                        if (pause) begin
                            state   <= BE_PAUSED;
                            running <= 1'b0;
                        end else if (tick_en) begin
                            if (sum >= LIMIT_V) begin
                                acc       <= sum - LIMIT_V;
                                sub_pulse <= 1'b1;
                                if (sub_idx == SUB_LAST) begin
                                    sub_idx    <= '0;
                                    beat_pulse <= 1'b1;
                                    beat_level <= ~beat_level;
                                    if (beat_idx == BEAT_LAST) begin
                                        beat_idx  <= '0;
                                        bar_pulse <= 1'b1;
                                    end else begin
                                        beat_idx <= beat_idx + BEAT_W'(1);
                                    end
                                end else begin
                                    sub_idx <= sub_idx + SUB_W'(1);
                                end
                            end else begin
                                acc <= sum;
                            end
                        end
                    end
                    BE_PAUSED: begin
                        if (!pause) begin
                            state   <= BE_RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= BE_IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_beat_engine.sv
// Directed bench for beat_engine: level tempi, endless ramp, pause, restart, reset, bar wrap.
// Latency: outputs sampled on the negedge following the posedge that consumed the inputs.
// Backpressure: n/a.
module tb_beat_engine;
    import beat_engine_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       tick_en;
    logic       sec_en;
    logic [1:0] mode;
    logic       start;
    logic       pause;
    logic       restart;
    logic       sub_pulse;
    logic       beat_pulse;
    logic       bar_pulse;
    logic       beat_level;
    logic [3:0] sub_idx;
    logic [1:0] beat_idx;
    logic [8:0] bpm_cur;
    logic       running;

    int checks   = 0;
    int failures = 0;
    int tick_no  = 0;

    int         sub_ticks[$];
    int         beat_ticks[$];
    int         bar_ticks[$];
    logic [1:0] beat_idx_log[$];
    logic       level_log[$];

    beat_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_en    (tick_en),
        .sec_en     (sec_en),
        .mode       (mode),
        .start      (start),
        .pause      (pause),
        .restart    (restart),
        .sub_pulse  (sub_pulse),
        .beat_pulse (beat_pulse),
        .bar_pulse  (bar_pulse),
        .beat_level (beat_level),
        .sub_idx    (sub_idx),
        .beat_idx   (beat_idx),
        .bpm_cur    (bpm_cur),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_log();
        tick_no = 0;
        sub_ticks.delete();
        beat_ticks.delete();
        bar_ticks.delete();
        beat_idx_log.delete();
        level_log.delete();
    endtask

    // Drive n consecutive tick_en cycles, recording the tick number of every pulse
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_en = 1'b1;
            tick_no++;
            @(negedge clk);
            if (sub_pulse) sub_ticks.push_back(tick_no);
            if (beat_pulse) begin
                beat_ticks.push_back(tick_no);
                beat_idx_log.push_back(beat_idx);
                level_log.push_back(beat_level);
            end
            if (bar_pulse) bar_ticks.push_back(tick_no);
        end
        tick_en = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic pulse_sec();
        sec_en = 1'b1;
        @(negedge clk);
        sec_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick_en = 1'b0; sec_en = 1'b0; start = 1'b0;
        pause = 1'b0; restart = 1'b0; mode = MODE_LEVEL_1;
        repeat (3) @(negedge clk);
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%0d exp=0", running); end
        checks++; if (beat_level !== 1'b1) begin failures++; $display("FAIL reset_beat_level got=%0d exp=1", beat_level); end
        checks++; if (sub_idx !== 4'd0 || beat_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d/%0d exp=0/0", sub_idx, beat_idx); end
        checks++; if ({sub_pulse, beat_pulse, bar_pulse} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {sub_pulse, beat_pulse, bar_pulse}); end
        checks++; if (bpm_cur !== 9'd60) begin failures++; $display("FAIL reset_bpm got=%0d exp=60", bpm_cur); end
        rst_n = 1'b1;
        clear_log();
        run_ticks(1500);
        checks++; if (sub_ticks.size() != 0 || running !== 1'b0) begin failures++; $display("FAIL idle_no_pulse subs=%0d running=%0d exp=0/0", sub_ticks.size(), running); end
    endtask

    task automatic test_level1();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL l1_running got=%0d exp=1", running); end
        clear_log();
        run_ticks(20000);
        checks++; if (sub_ticks.size() != 20) begin failures++; $display("FAIL l1_sub_count got=%0d exp=20", sub_ticks.size()); end
        checks++; if (sub_ticks[0] != 1000 || sub_ticks[19] != 20000) begin failures++; $display("FAIL l1_sub_ticks got=%0d,%0d exp=1000,20000", sub_ticks[0], sub_ticks[19]); end
        checks++; if (beat_ticks.size() != 2 || beat_ticks[0] != 10000 || beat_ticks[1] != 20000) begin failures++; $display("FAIL l1_beat_ticks n=%0d got=%0d,%0d exp=10000,20000", beat_ticks.size(), beat_ticks[0], beat_ticks[1]); end
        checks++; if (level_log[0] !== 1'b0 || level_log[1] !== 1'b1) begin failures++; $display("FAIL l1_beat_level got=%0d,%0d exp=0,1", level_log[0], level_log[1]); end
        checks++; if (bar_ticks.size() != 0) begin failures++; $display("FAIL l1_no_bar got=%0d exp=0", bar_ticks.size()); end
    endtask

    task automatic test_level2();
        mode = MODE_LEVEL_2;
        pulse_restart();
        checks++; if (bpm_cur !== 9'd90) begin failures++; $display("FAIL l2_bpm got=%0d exp=90", bpm_cur); end
        clear_log();
        run_ticks(20000);
        checks++; if (sub_ticks[0] != 667 || sub_ticks[1] != 1334 || sub_ticks[2] != 2000 || sub_ticks[3] != 2667) begin
            failures++; $display("FAIL l2_sub_ticks got=%0d,%0d,%0d,%0d exp=667,1334,2000,2667", sub_ticks[0], sub_ticks[1], sub_ticks[2], sub_ticks[3]);
        end
        checks++; if (sub_ticks.size() != 30) begin failures++; $display("FAIL l2_sub_count got=%0d exp=30", sub_ticks.size()); end
        checks++; if (beat_ticks.size() != 3 || beat_ticks[2] != 20000) begin failures++; $display("FAIL l2_beats n=%0d last=%0d exp=3/20000", beat_ticks.size(), beat_ticks[2]); end
    endtask

    task automatic test_endless();
        int max_seen;
        mode = MODE_ENDLESS;
        pulse_restart();
        checks++; if (bpm_cur !== 9'd60) begin failures++; $display("FAIL end_start got=%0d exp=60", bpm_cur); end
        pulse_sec();
        checks++; if (bpm_cur !== 9'd64) begin failures++; $display("FAIL end_step1 got=%0d exp=64", bpm_cur); end
        pulse_sec();
        checks++; if (bpm_cur !== 9'd68) begin failures++; $display("FAIL end_step2 got=%0d exp=68", bpm_cur); end
        pulse_sec();
        checks++; if (bpm_cur !== 9'd72) begin failures++; $display("FAIL end_step3 got=%0d exp=72", bpm_cur); end
        // sec_en while paused must not ramp
        pause = 1'b1;
        @(negedge clk);
        pulse_sec();
        pause = 1'b0;
        @(negedge clk);
        checks++; if (bpm_cur !== 9'd72) begin failures++; $display("FAIL end_pause_frozen got=%0d exp=72", bpm_cur); end
        mode = MODE_LEVEL_3;
        #1;
        checks++; if (bpm_cur !== 9'd120) begin failures++; $display("FAIL end_mode_l3 got=%0d exp=120", bpm_cur); end
        mode = MODE_ENDLESS;
        #1;
        checks++; if (bpm_cur !== 9'd72) begin failures++; $display("FAIL end_mode_back got=%0d exp=72", bpm_cur); end
        repeat (4) pulse_sec();
        checks++; if (bpm_cur !== 9'd93) begin failures++; $display("FAIL end_step7 got=%0d exp=93", bpm_cur); end
        max_seen = 0;
        for (int i = 0; i < 30; i++) begin
            pulse_sec();
            if (int'(bpm_cur) > max_seen) max_seen = int'(bpm_cur);
        end
        checks++; if (bpm_cur !== 9'd240 || max_seen != 240) begin failures++; $display("FAIL end_saturate got=%0d max=%0d exp=240", bpm_cur, max_seen); end
    endtask

    task automatic test_pause();
        mode = MODE_LEVEL_1;
        pulse_restart();
        clear_log();
        run_ticks(1300);
        checks++; if (sub_idx !== 4'd1 || sub_ticks.size() != 1) begin failures++; $display("FAIL pause_pre sub_idx=%0d subs=%0d exp=1/1", sub_idx, sub_ticks.size()); end
        pause = 1'b1;
        clear_log();
        run_ticks(5000);
        checks++; if (sub_ticks.size() != 0 || beat_ticks.size() != 0) begin failures++; $display("FAIL pause_no_pulse subs=%0d beats=%0d exp=0/0", sub_ticks.size(), beat_ticks.size()); end
        checks++; if (running !== 1'b0 || sub_idx !== 4'd1 || beat_idx !== 2'd0) begin failures++; $display("FAIL pause_hold running=%0d sub=%0d beat=%0d exp=0/1/0", running, sub_idx, beat_idx); end
        pause = 1'b0;
        @(negedge clk);
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL pause_resume got=%0d exp=1", running); end
        clear_log();
        run_ticks(700);
        checks++; if (sub_ticks.size() != 1 || sub_ticks[0] != 700 || sub_idx !== 4'd2) begin failures++; $display("FAIL pause_remaining at=%0d sub_idx=%0d exp=700/2", sub_ticks[0], sub_idx); end
    endtask

    task automatic test_restart();
        mode = MODE_ENDLESS;
        pulse_restart();
        clear_log();
        run_ticks(2500);
        pulse_sec();
        checks++; if (bpm_cur !== 9'd64 || sub_idx !== 4'd2) begin failures++; $display("FAIL rst_pre bpm=%0d sub=%0d exp=64/2", bpm_cur, sub_idx); end
        pulse_restart();
        checks++; if (sub_idx !== 4'd0 || beat_idx !== 2'd0 || running !== 1'b1 || bpm_cur !== 9'd60) begin
            failures++; $display("FAIL restart_clear sub=%0d beat=%0d run=%0d bpm=%0d exp=0/0/1/60", sub_idx, beat_idx, running, bpm_cur);
        end
        clear_log();
        run_ticks(1000);
        checks++; if (sub_ticks.size() != 1 || sub_ticks[0] != 1000) begin failures++; $display("FAIL restart_first_sub n=%0d at=%0d exp=1/1000", sub_ticks.size(), sub_ticks[0]); end
    endtask

    task automatic test_bar_and_reset();
        mode = MODE_LEVEL_3;
        pulse_restart();
        clear_log();
        run_ticks(20000);
        checks++; if (sub_ticks[0] != 500) begin failures++; $display("FAIL bar_sub_period got=%0d exp=500", sub_ticks[0]); end
        checks++; if (beat_ticks.size() != 4 || beat_ticks[0] != 5000 || beat_ticks[3] != 20000) begin failures++; $display("FAIL bar_beats n=%0d first=%0d last=%0d exp=4/5000/20000", beat_ticks.size(), beat_ticks[0], beat_ticks[3]); end
        checks++; if (beat_idx_log[0] !== 2'd1 || beat_idx_log[1] !== 2'd2 || beat_idx_log[2] !== 2'd3 || beat_idx_log[3] !== 2'd0) begin
            failures++; $display("FAIL bar_beat_idx got=%0d,%0d,%0d,%0d exp=1,2,3,0", beat_idx_log[0], beat_idx_log[1], beat_idx_log[2], beat_idx_log[3]);
        end
        checks++; if (bar_ticks.size() != 1 || bar_ticks[0] != 20000) begin failures++; $display("FAIL bar_pulse n=%0d at=%0d exp=1/20000", bar_ticks.size(), bar_ticks[0]); end
        run_ticks(5100);
        checks++; if (beat_level !== 1'b0 || beat_idx !== 2'd1) begin failures++; $display("FAIL bar_mid level=%0d beat=%0d exp=0/1", beat_level, beat_idx); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (running !== 1'b0 || beat_level !== 1'b1 || sub_idx !== 4'd0 || beat_idx !== 2'd0) begin
            failures++; $display("FAIL midbar_reset run=%0d level=%0d sub=%0d beat=%0d exp=0/1/0/0", running, beat_level, sub_idx, beat_idx);
        end
        mode = MODE_LEVEL_1;
        clear_log();
        run_ticks(2000);
        checks++; if (sub_ticks.size() != 0 || running !== 1'b0) begin failures++; $display("FAIL reset_idle subs=%0d run=%0d exp=0/0", sub_ticks.size(), running); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear_log();
        run_ticks(1000);
        checks++; if (sub_ticks.size() != 1 || sub_ticks[0] != 1000) begin failures++; $display("FAIL reset_restart_sub n=%0d at=%0d exp=1/1000", sub_ticks.size(), sub_ticks[0]); end
    endtask

    initial begin
        test_reset();
        test_level1();
        test_level2();
        test_endless();
        test_pause();
        test_restart();
        test_bar_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/beat_engine.md
Name: beat_engine

Overview:
Parametrised successor to the level/endless tempo generator. It runs entirely in the `clk` domain and produces single-cycle enable pulses instead of derived clocks. Tempo is synthesised with a phase accumulator, so no runtime divider is needed. It adds start/pause/resume control, configurable subdivision and bar length, a saturating endless-mode ramp, and beat/bar position outputs for the note scroller and score logic.

Parameters:
TICK_HZ, 10000, rate of the tick_en pulses.
SUBDIV, 10, sub-beats per beat.
BEATS_PER_BAR, 4, beats per bar.
BPM_W, 9, width of the BPM value.
BPM_L1 / BPM_L2 / BPM_L3, 60 / 90 / 120, fixed tempi for levels 1-3.
BPM_START, 60, endless-mode start tempo.
BPM_MAX, 240, endless-mode tempo ceiling.
RAMP_NUM / RAMP_DEN, 15 / 14, endless ramp ratio applied once per sec_en.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
tick_en  in  1  one-cycle pulse at TICK_HZ
sec_en  in  1  one-cycle pulse at 1 Hz
mode  in  2  level select; codes are state_endless / state_level_1 / state_level_2 / state_level_3 from global.v
start  in  1  one-cycle pulse: IDLE->RUN
pause  in  1  level: hold while RUN
restart  in  1  one-cycle pulse: clear and enter RUN
sub_pulse  out  1  one-cycle pulse per sub-beat
beat_pulse  out  1  one-cycle pulse per beat
bar_pulse  out  1  one-cycle pulse per bar
beat_level  out  1  square wave, toggles on each beat_pulse
sub_idx  out  clog2(SUBDIV)  current sub-beat index
beat_idx  out  clog2(BEATS_PER_BAR)  current beat-in-bar index
bpm_cur  out  BPM_W  active tempo
running  out  1  high in RUN

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - FSM=IDLE; acc=0; sub_idx=0; beat_idx=0; endless bpm=BPM_START.
  - All pulses 0; beat_level=1; running=0.
- FSM states IDLE, RUN, PAUSED. Priority is rst_n > restart > start > pause.
  - IDLE: start -> RUN.
  - RUN: pause=1 -> PAUSED.
  - PAUSED: pause=0 -> RUN. Accumulator, indices and bpm are frozen while PAUSED.
  - restart in any state: same clears as reset except FSM -> RUN; running=1 next cycle.
  - start is ignored outside IDLE.
- bpm_cur is combinational from mode:
  - levels 1-3 select BPM_L1, BPM_L2, BPM_L3.
  - endless selects the ramp register.
  - A mode change takes effect on the next tick; acc is not cleared.
- Endless ramp applies on sec_en while in RUN with mode=endless:
  - nxt = (bpm*RAMP_NUM)/RAMP_DEN; if nxt==bpm then nxt=bpm+1.
  - Result saturates at BPM_MAX.
  - Intermediate width is BPM_W+clog2(RAMP_NUM)+1, with no overflow.
- Phase accumulator:
  - LIMIT = TICK_HZ*60.
  - On tick_en in RUN: sum = acc + bpm_cur*SUBDIV.
  - If sum >= LIMIT: acc <= sum-LIMIT and sub_pulse is asserted next cycle; otherwise acc <= sum.
  - Elaboration check: BPM_MAX*SUBDIV < LIMIT, so there is at most one sub-beat per tick.
- On each sub-beat, sub_idx increments and wraps at SUBDIV-1 -> 0.
- On that wrap, in the same cycle as the sub_pulse:
  - beat_pulse=1 and beat_level toggles.
  - beat_idx increments and wraps at BEATS_PER_BAR-1.
  - When beat_idx wraps, bar_pulse=1.
- Latency: one clk from the qualifying tick_en to sub_pulse, beat_pulse and bar_pulse. The pulses are coincident and last exactly one cycle.
- tick_en and sec_en in the same cycle are both processed. The accumulator uses the pre-ramp bpm.
- tick_en during a pause or restart cycle is dropped.

Decomposition:
- Extend global.v with: mode codes (already present), FSM state encodings BE_IDLE / BE_RUN / BE_PAUSED, and the default tempo constants.
- One natural sub-module: tempo_ramp, the combinational plus registered endless BPM update with saturation.
- Accumulator, index counters and FSM stay in beat_engine.

Test Plan:
- Defaults, mode=level_1, start, 20000 tick_en -> sub_pulse every 1000 ticks; beat_pulse at ticks 10000 and 20000; beat_level 1->0->1.
- mode=level_2 -> sub-beat intervals of 667/667/666 ticks repeating; 3 beats in exactly 20000 ticks; bpm_cur=90.
- mode=endless, start, sec_en x3 -> bpm_cur 60->64->68->72; keep pulsing sec_en -> bpm_cur saturates at 240 and stays there.
- pause held for 5000 ticks mid-beat -> no pulses, sub_idx/beat_idx/acc unchanged; release -> the next sub_pulse arrives at the remaining tick count.
- 4 beats at level_3 (500 ticks per sub) -> bar_pulse coincident with the 4th beat_pulse; beat_idx 0,1,2,3,0.
- restart mid-bar, and rst_n=0 mid-bar -> restart: indices 0, bpm 60, running=1, next sub_pulse after 1000 ticks; reset: IDLE, running=0, beat_level=1, no pulses until start.
